// File: rtl/fire2_pkg.sv
// Shared sizing, the weight word type and the sequencer state encoding for the
// fire2 squeeze weight path.
package fire2_pkg;

  localparam int WIDTH  = 16;
  localparam int NUM    = 16;
  localparam int ADDR   = 10;
  localparam int DEPTH  = 576;
  localparam int PASSES = 3025;

  typedef logic [NUM-1:0][WIDTH-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fire2_squeeze_weight_seq_fifo.sv
// weight_skid_fifo: 3-entry skid buffer between the ROM capture and the MAC
// handshake; payload width is a parameter.
module weight_skid_fifo #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [PW-1:0] push_data,
  input  logic          pop,
  output logic [PW-1:0] pop_data,
  output logic [1:0]    count,
  output logic          full,
  output logic          empty
);
  import fire2_pkg::*;

  logic [PW-1:0] mem [0:2];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd3);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // storage is data only; emptiness is tracked by the reset count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fire2_squeeze_weight_seq.sv
// Sweeps the squeeze weight ROM once per output pass and streams the words to the
// MAC array. Optional macro FIRE2_SEQ_STALL_CNT_EN adds a stall_cycles counter.
module fire2_squeeze_weight_seq #(
  parameter int WIDTH  = fire2_pkg::WIDTH,
  parameter int NUM    = fire2_pkg::NUM,
  parameter int ADDR   = fire2_pkg::ADDR,
  parameter int DEPTH  = fire2_pkg::DEPTH,
  parameter int PASSES = fire2_pkg::PASSES,
  parameter int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR-1:0]   rom_addr,
  input  logic [WIDTH-1:0]  rom_data [0:NUM-1],
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WIDTH-1:0]  w_data [0:NUM-1],
  output logic              w_first,
  output logic              w_last,
  output logic [PASS_W-1:0] pass_idx
`ifdef FIRE2_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  import fire2_pkg::*;

  localparam int LW = WIDTH * NUM;
  localparam int PW = LW + 2 + PASS_W;

  state_t            state;
  logic [ADDR-1:0]   addr_cnt;
  logic [PASS_W-1:0] pass_cnt;
  logic              inflight;
  logic              inf_first;
  logic              inf_last;
  logic [PASS_W-1:0] inf_pass;

  logic              issue;
  logic              last_addr;
  logic              last_pass;
  logic              fifo_push;
  logic              fifo_pop;
  logic [PW-1:0]     push_word;
  logic [PW-1:0]     head;
  logic [1:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  assign last_addr = (addr_cnt == ADDR'(DEPTH - 1));
  assign last_pass = (pass_cnt == PASS_W'(PASSES - 1));
  // the count of words held or on their way never exceeds the FIFO depth
  assign issue     = (state == RUN) && (({1'b0, fifo_count} + {2'b0, inflight}) < 3'd3);
  assign rom_addr  = addr_cnt;

  // issue stage: address sweep, pass counting and run control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      addr_cnt  <= '0;
      pass_cnt  <= '0;
      inflight  <= 1'b0;
      inf_first <= 1'b0;
      inf_last  <= 1'b0;
      inf_pass  <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inf_first <= (addr_cnt == '0);
        inf_last  <= last_addr;
        inf_pass  <= pass_cnt;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            addr_cnt <= '0;
            pass_cnt <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            if (last_addr) begin
              addr_cnt <= '0;
              if (last_pass) begin
                state    <= DRAIN;
                pass_cnt <= '0;
              end else begin
                pass_cnt <= pass_cnt + PASS_W'(1);
              end
            end else begin
              addr_cnt <= addr_cnt + ADDR'(1);
            end
          end
        end
        DRAIN: begin
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // capture stage: ROM word plus its tags enter the skid buffer
  always_comb begin
    push_word = '0;
    for (int i = 0; i < NUM; i++) push_word[i*WIDTH +: WIDTH] = rom_data[i];
    push_word[LW +: PASS_W]   = inf_pass;
    push_word[LW + PASS_W]     = inf_last;
    push_word[LW + PASS_W + 1] = inf_first;
  end

  assign fifo_push = inflight && !fifo_full;
  assign fifo_pop  = w_valid && w_ready;

  weight_skid_fifo #(
    .PW(PW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(push_word),
    .pop      (fifo_pop),
    .pop_data (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // output stage: head of the buffer, forced to zero while nothing is held
  assign w_valid = !fifo_empty;

  always_comb begin
    for (int i = 0; i < NUM; i++) w_data[i] = w_valid ? head[i*WIDTH +: WIDTH] : '0;
    pass_idx = w_valid ? head[LW +: PASS_W] : '0;
    w_last   = w_valid && head[LW + PASS_W];
    w_first  = w_valid && head[LW + PASS_W + 1];
  end

  assign done = fifo_pop && (state == DRAIN) && head[LW + PASS_W] &&
                (head[LW +: PASS_W] == PASS_W'(PASSES - 1));

`ifdef FIRE2_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (start && (state == IDLE)) begin
      stall_cycles <= '0;
    end else if (w_valid && !w_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fire2_squeeze_weight_seq.sv
// Directed bench for fire2_squeeze_weight_seq: a DEPTH=4/PASSES=2 instance for the
// main sequence and a DEPTH=1/PASSES=3 instance for the single-word corner.
module tb_fire2_squeeze_weight_seq;

  localparam int WIDTH = 16;
  localparam int NUM   = 16;
  localparam int ADDR  = 10;

  logic clk;
  logic rst_n;

  logic             start, busy, done, w_valid, w_ready, w_first, w_last;
  logic [ADDR-1:0]  rom_addr;
  logic [WIDTH-1:0] rom_q  [0:NUM-1];
  logic [WIDTH-1:0] w_data [0:NUM-1];
  logic [0:0]       pass_idx;

  logic             start1, busy1, done1, w_valid1, w_ready1, w_first1, w_last1;
  logic [ADDR-1:0]  rom_addr1;
  logic [WIDTH-1:0] rom_q1  [0:NUM-1];
  logic [WIDTH-1:0] w_data1 [0:NUM-1];
  logic [1:0]       pass_idx1;

`ifdef FIRE2_SEQ_STALL_CNT_EN
  logic [31:0] stall_cycles, stall_cycles1;
`endif

  int n_vec = 0;
  int n_err = 0;

  fire2_squeeze_weight_seq #(
    .WIDTH(WIDTH), .NUM(NUM), .ADDR(ADDR), .DEPTH(4), .PASSES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_q), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_first(w_first), .w_last(w_last), .pass_idx(pass_idx)
`ifdef FIRE2_SEQ_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  fire2_squeeze_weight_seq #(
    .WIDTH(WIDTH), .NUM(NUM), .ADDR(ADDR), .DEPTH(1), .PASSES(3)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .rom_addr(rom_addr1), .rom_data(rom_q1), .w_valid(w_valid1), .w_ready(w_ready1),
    .w_data(w_data1), .w_first(w_first1), .w_last(w_last1), .pass_idx(pass_idx1)
`ifdef FIRE2_SEQ_STALL_CNT_EN
    , .stall_cycles(stall_cycles1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered ROM models: lane i of address a holds {a, i}
  always @(posedge clk) begin
    for (int i = 0; i < NUM; i++) begin
      rom_q[i]  <= WIDTH'({rom_addr, 4'(i)});
      rom_q1[i] <= WIDTH'({rom_addr1, 4'(i)});
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int a);
    return {WIDTH'(a * 16 + 15), WIDTH'(a * 16)};
  endfunction

  function automatic logic [31:0] cur_word();
    return {w_data[NUM-1], w_data[0]};
  endfunction

  function automatic logic rdy(input int mode, input int cyc);
    case (mode)
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       return cyc > 20;
      default: return 1'b1;
    endcase
  endfunction

  // mode 0: ready held; 1: ready 1,0,0,1; 2: ready low to cycle 20; 3: stray start at 5
  task automatic run_a(input int mode);
    int cyc, k, done_cnt, done_cyc, first_v, stalls;
    logic        prev_stall;
    logic [63:0] prev, cur;
    cyc = 0; k = 0; done_cnt = 0; done_cyc = -1; first_v = -1; stalls = 0;
    prev_stall = 1'b0; prev = '0;
    start = 1'b1;
    w_ready = rdy(mode, 0);
    for (int t = 0; t < 80; t++) begin
      #1;
      cur = {29'd0, cur_word(), w_first, w_last, pass_idx};
      if (cyc == 1) begin
        chk("busy_c1", 64'(busy), 64'd1);
        chk("addr_c1", 64'(rom_addr), 64'd0);
      end
      if (mode == 2 && cyc == 20) begin
        chk("hold_addr", 64'(rom_addr), 64'd3);
        chk("hold_valid", 64'(w_valid), 64'd1);
        chk("hold_word", 64'(cur_word()), 64'(exp_word(0)));
      end
      if (w_valid && first_v < 0) first_v = cyc;
      if (prev_stall) chk("stall_stable", cur, prev);
      if (w_valid && w_ready) begin
        chk("word", 64'(cur_word()), 64'(exp_word(k % 4)));
        chk("first", 64'(w_first), 64'(k % 4 == 0));
        chk("last", 64'(w_last), 64'(k % 4 == 3));
        chk("pass", 64'(pass_idx), 64'(k / 4));
        chk("done_on_accept", 64'(done), 64'(k == 7));
        k++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) chk("busy_after_done", 64'(busy), 64'd0);
      if (w_valid && !w_ready) stalls++;
      prev_stall = w_valid && !w_ready;
      prev = cur;
      @(posedge clk);
      #1;
      cyc++;
      start = (mode == 3) && (cyc == 5);
      w_ready = rdy(mode, cyc);
    end
    start = 1'b0;
    chk("n_words", 64'(k), 64'd8);
    chk("n_done", 64'(done_cnt), 64'd1);
    chk("first_valid_cyc", 64'(first_v), 64'd3);
    if (mode == 0 || mode == 3) chk("done_cyc", 64'(done_cyc), 64'd10);
`ifdef FIRE2_SEQ_STALL_CNT_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(stalls));
`endif
  endtask

  initial begin
    int k1, dcnt1;
    rst_n = 1'b0; start = 1'b0; w_ready = 1'b0; start1 = 1'b0; w_ready1 = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);
    chk("rst_valid", 64'(w_valid), 64'd0);
    chk("rst_tags", 64'({w_first, w_last, pass_idx}), 64'd0);
    chk("rst_data", 64'(cur_word()), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_a(0);
    run_a(1);
    run_a(2);
    run_a(3);

    // asynchronous reset in the middle of cycle 6
    start = 1'b1; w_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_valid", 64'(w_valid), 64'd1);
    #4;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(w_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_addr", 64'(rom_addr), 64'd0);
    chk("midrst_pass", 64'(pass_idx), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_a(0);

    // single-word sweep, three passes
    k1 = 0; dcnt1 = 0;
    start1 = 1'b1; w_ready1 = 1'b1;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (w_valid1 && w_ready1) begin
        chk("d1_first", 64'(w_first1), 64'd1);
        chk("d1_last", 64'(w_last1), 64'd1);
        chk("d1_pass", 64'(pass_idx1), 64'(k1));
        chk("d1_done", 64'(done1), 64'(k1 == 2));
        k1++;
      end
      if (done1) dcnt1++;
      @(posedge clk); #1;
      start1 = 1'b0;
    end
    chk("d1_words", 64'(k1), 64'd3);
    chk("d1_ndone", 64'(dcnt1), 64'd1);
    chk("d1_busy_end", 64'(busy1), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
